sdram_dbus_arbiter: RTL and testbench
=====================================

// Module: sdram_dbus_arbiter
// PURPOSE
//  Two-master round-robin arbiter feeding the single dbus port of sdram_controller.
//  Each master port is a burst dbus slave with the same signal set as the controller's dbus.
//  Write bursts are locked to one master until the last beat. Read bursts are one command each.
//  Read data returns in command order and is routed back via an in-order tag queue.
// PARAMETERS
//  ADDR_W      25  dbus word address width
//  DATA_W      16  data width
//  BE_W        2   byteenable width (DATA_W/8)
//  BURST_W     7   burstcount width
//  RDQ_DEPTH   4   max outstanding read bursts (power of 2)
// PORTS
//  clk               in   1        system clock, same as sdram_controller
//  rst               in   1        synchronous, active-high reset
//  mN_address        in   ADDR_W   master N (N=0,1) address
//  mN_writedata      in   DATA_W   master N write data
//  mN_byteenable     in   BE_W     master N byte enables
//  mN_burstcount     in   BURST_W  master N burst length (0 treated as 1)
//  mN_read/mN_write  in   1        master N command strobes (both high = protocol error, write wins)
//  mN_waitrequest    out  1        master N stall
//  mN_readdata       out  DATA_W   broadcast copy of dbus_readdata
//  mN_readdatavalid  out  1        read beat for master N
//  dbus_address..dbus_write  out   selected master's command to controller (same widths)
//  dbus_waitrequest  in   1        controller stall
//  dbus_readdata     in   DATA_W   controller read data
//  dbus_readdatavalid in  1        controller read beat valid
//  rsp_orphan        out  1        sticky: readdatavalid arrived with empty tag queue
// BEHAVIOUR
//  - Reset: state IDLE, last_grant=1 (m0 wins first tie), tag queue empty, rsp_orphan=0.
//    While rst=1: dbus_read=dbus_write=0, m0/m1_waitrequest=1, mN_readdatavalid=0.
//  - States: IDLE, WBURST. Command path is combinational mux of the selected master, no added latency.
//  - IDLE: eligible(N) = mN_write | (mN_read & !rdq_full). sel = sole eligible master, or
//    !last_grant if both. Unselected master: waitrequest=1. Selected: waitrequest=dbus_waitrequest.
//    No eligible master: dbus_read=dbus_write=0, sel held.
//  - Accepted read (dbus_read & !dbus_waitrequest): push {sel, burstcount(0->1)} into tag queue;
//    last_grant<=sel; stay IDLE.
//  - Accepted write, burstcount<=1: last_grant<=sel; stay IDLE.
//  - Accepted write, burstcount>1: lock sel, beats_left<=burstcount-1, go WBURST.
//  - WBURST: only locked master forwarded (its read strobe masked); other master waitrequest=1.
//    Each accepted beat decrements beats_left; accept at beats_left==1 -> last_grant<=sel, IDLE.
//    Master deasserting write mid-burst: dbus_write=0, burst stays locked (no timeout).
//  - Response: on dbus_readdatavalid, head.id master gets readdatavalid=1; head.count decrements;
//    pop when count reaches 0. Push and pop in the same cycle are both honoured.
//  - rdq_full masks reads only; writes still granted. Orphan beat: dropped, rsp_orphan<=1.
//  - beats_left/count are BURST_W wide; burstcount max 2^BURST_W-1, no wrap.
//  - Reset mid-burst: state, queue, counters cleared next edge; in-flight beats are lost.
// STRUCTURE
//  - Package sdram_dbus_pkg: ADDR_W/DATA_W/BE_W/BURST_W constants, state enum {IDLE,WBURST},
//    rd_tag_t struct {id:1, count:BURST_W}.
//  - Sub-module sdram_rd_tag_fifo: synchronous FIFO of rd_tag_t, RDQ_DEPTH deep, with head
//    count-decrement port, full/empty flags.
//  - Top: arbiter FSM, round-robin pointer, combinational command mux.
// TESTING
//  - m0 write addr 0x000000 data 0xFFFF bc=1, m1 idle -> one dbus write, m0_waitrequest follows controller.
//  - Both masters write bc=8 same cycle after reset -> m0 gets 8 beats, then m1 8 beats, no interleave.
//  - m0 read bc=16, m1 read bc=1 back-to-back -> 16 beats with m0_readdatavalid, then 1 with m1's.
//  - 4 outstanding m1 reads (queue full) + m1 read + m0 write -> m1 read stalled, m0 write granted.
//  - Inject dbus_readdatavalid with empty queue -> no mN_readdatavalid, rsp_orphan=1 until rst.
//  - rst pulse during beat 3 of 8-beat write -> next cycle IDLE, both waitrequest=1 during rst, queue empty.

Source files
------------

// File: rtl/sdram_dbus_pkg.sv
// Shared constants and types for the two-master SDRAM dbus arbiter.
package sdram_dbus_pkg;

   localparam int unsigned ADDR_W  = 25;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned BE_W    = DATA_W / 8;
   localparam int unsigned BURST_W = 7;

   typedef enum logic [0:0] {
      StIdle,
      StWburst
   } arb_state_e;

   typedef struct packed {
      logic               id;
      logic [BURST_W-1:0] count;
   } rd_tag_t;

endpackage

// File: rtl/sdram_rd_tag_fifo.sv
// In-order read tag queue; the head's beat count is decremented per returned beat
// and the entry is popped when its last beat arrives.
module sdram_rd_tag_fifo
   import sdram_dbus_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push_i,
   input  rd_tag_t push_tag_i,
   input  logic    dec_i,
   output logic    head_id_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   rd_tag_t       mem_q [Depth];
   rd_tag_t       mem_d [Depth];
   logic [PtrW:0] wr_q, wr_d, rd_q, rd_d;
   logic [PtrW-1:0] rd_idx, wr_idx;

   assign rd_idx    = rd_q[PtrW-1:0];
   assign wr_idx    = wr_q[PtrW-1:0];
   assign empty_o   = (wr_q == rd_q);
   assign full_o    = (wr_q[PtrW] != rd_q[PtrW]) && (wr_idx == rd_idx);
   assign head_id_o = mem_q[rd_idx].id;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (dec_i && !empty_o) begin
         if (mem_q[rd_idx].count == BURST_W'(1)) begin
            rd_d = rd_q + 1'b1;
         end else begin
            mem_d[rd_idx].count = mem_q[rd_idx].count - 1'b1;
         end
      end
      // A full queue never sees a push from the arbiter, so the slots cannot collide.
      if (push_i && !full_o) begin
         mem_d[wr_idx] = push_tag_i;
         wr_d          = wr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/sdram_dbus_arbiter.sv
// Two-master round-robin arbiter for the sdram_controller dbus; write bursts are locked
// to one master and read beats are steered back through an in-order tag queue.
module sdram_dbus_arbiter
   import sdram_dbus_pkg::*;
#(
   parameter int unsigned RDQ_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  m0_address,
   input  logic [DATA_W-1:0]  m0_writedata,
   input  logic [BE_W-1:0]    m0_byteenable,
   input  logic [BURST_W-1:0] m0_burstcount,
   input  logic               m0_read,
   input  logic               m0_write,
   output logic               m0_waitrequest,
   output logic [DATA_W-1:0]  m0_readdata,
   output logic               m0_readdatavalid,
   input  logic [ADDR_W-1:0]  m1_address,
   input  logic [DATA_W-1:0]  m1_writedata,
   input  logic [BE_W-1:0]    m1_byteenable,
   input  logic [BURST_W-1:0] m1_burstcount,
   input  logic               m1_read,
   input  logic               m1_write,
   output logic               m1_waitrequest,
   output logic [DATA_W-1:0]  m1_readdata,
   output logic               m1_readdatavalid,
   output logic [ADDR_W-1:0]  dbus_address,
   output logic [DATA_W-1:0]  dbus_writedata,
   output logic [BE_W-1:0]    dbus_byteenable,
   output logic [BURST_W-1:0] dbus_burstcount,
   output logic               dbus_read,
   output logic               dbus_write,
   input  logic               dbus_waitrequest,
   input  logic [DATA_W-1:0]  dbus_readdata,
   input  logic               dbus_readdatavalid,
   output logic               rsp_orphan
);

   arb_state_e         state_q, state_d;
   logic               sel_q, sel_d;
   logic               last_q, last_d;
   logic [BURST_W-1:0] beats_q, beats_d;
   logic               orphan_q, orphan_d;

   logic [ADDR_W-1:0]  m_addr [2];
   logic [DATA_W-1:0]  m_wdata [2];
   logic [BE_W-1:0]    m_be [2];
   logic [BURST_W-1:0] m_bc [2];
   logic [1:0]         m_wr, m_rd, m_wait, m_rdv, elig;
   logic               cur;
   logic [BURST_W-1:0] bc_eff;
   logic               rdq_push, rdq_dec, rdq_full, rdq_empty, rdq_head_id;
   rd_tag_t            push_tag;

   assign m_addr[0]  = m0_address;
   assign m_addr[1]  = m1_address;
   assign m_wdata[0] = m0_writedata;
   assign m_wdata[1] = m1_writedata;
   assign m_be[0]    = m0_byteenable;
   assign m_be[1]    = m1_byteenable;
   assign m_bc[0]    = m0_burstcount;
   assign m_bc[1]    = m1_burstcount;
   assign m_wr       = {m1_write, m0_write};
   assign m_rd       = {m1_read, m0_read};

   always_comb begin
      elig     = m_wr | (m_rd & {2{~rdq_full}});
      state_d  = state_q;
      sel_d    = sel_q;
      last_d   = last_q;
      beats_d  = beats_q;
      cur      = sel_q;
      m_wait   = 2'b11;
      dbus_read  = 1'b0;
      dbus_write = 1'b0;
      rdq_push   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (&elig) begin
               sel_d = ~last_q;
            end else if (elig[0]) begin
               sel_d = 1'b0;
            end else if (elig[1]) begin
               sel_d = 1'b1;
            end
            cur = sel_d;
            // A read blocked by a full tag queue stays stalled even when it holds the mux.
            if (elig[cur]) begin
               dbus_write  = m_wr[cur];
               dbus_read   = ~m_wr[cur] & m_rd[cur];
               m_wait[cur] = dbus_waitrequest;
            end
         end
         StWburst: begin
            dbus_write  = m_wr[cur];
            m_wait[cur] = dbus_waitrequest;
         end
         default: ;
      endcase

      bc_eff = (m_bc[cur] == '0) ? BURST_W'(1) : m_bc[cur];

      if (rst) begin
         dbus_read  = 1'b0;
         dbus_write = 1'b0;
         m_wait     = 2'b11;
      end

      if (dbus_write && !dbus_waitrequest) begin
         if (state_q == StWburst) begin
            beats_d = beats_q - 1'b1;
            if (beats_q == BURST_W'(1)) begin
               state_d = StIdle;
               last_d  = cur;
            end
         end else if (bc_eff > BURST_W'(1)) begin
            state_d = StWburst;
            beats_d = bc_eff - 1'b1;
         end else begin
            last_d = cur;
         end
      end

      if (dbus_read && !dbus_waitrequest) begin
         rdq_push = 1'b1;
         last_d   = cur;
      end
   end

   assign push_tag.id    = cur;
   assign push_tag.count = bc_eff;

   assign rdq_dec  = dbus_readdatavalid & ~rdq_empty & ~rst;
   assign m_rdv    = rdq_dec ? (rdq_head_id ? 2'b10 : 2'b01) : 2'b00;
   assign orphan_d = orphan_q | (dbus_readdatavalid & rdq_empty);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         sel_q    <= 1'b0;
         last_q   <= 1'b1;
         beats_q  <= '0;
         orphan_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         last_q   <= last_d;
         beats_q  <= beats_d;
         orphan_q <= orphan_d;
      end
   end

   sdram_rd_tag_fifo #(
      .Depth (RDQ_DEPTH)
   ) u_rd_tag_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (rdq_push),
      .push_tag_i (push_tag),
      .dec_i      (rdq_dec),
      .head_id_o  (rdq_head_id),
      .full_o     (rdq_full),
      .empty_o    (rdq_empty)
   );

   assign dbus_address     = m_addr[cur];
   assign dbus_writedata   = m_wdata[cur];
   assign dbus_byteenable  = m_be[cur];
   assign dbus_burstcount  = m_bc[cur];
   assign m0_waitrequest   = m_wait[0];
   assign m1_waitrequest   = m_wait[1];
   assign m0_readdata      = dbus_readdata;
   assign m1_readdata      = dbus_readdata;
   assign m0_readdatavalid = m_rdv[0];
   assign m1_readdatavalid = m_rdv[1];
   assign rsp_orphan       = orphan_q;

endmodule

// File: tb/tb_sdram_dbus_arbiter.sv
// Random two-master traffic against a transaction-level model of grant order,
// write-burst locking, read tag routing and orphan detection.
module tb_sdram_dbus_arbiter;
   import sdram_dbus_pkg::*;

   localparam int DEPTH  = 4;
   localparam int CYCLES = 20000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [ADDR_W-1:0]  drv_addr [2];
   logic [DATA_W-1:0]  drv_wdata [2];
   logic [BE_W-1:0]    drv_be [2];
   logic [BURST_W-1:0] drv_bc [2];
   logic               drv_rd [2];
   logic               drv_wr [2];

   logic               m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [DATA_W-1:0]  m0_readdata, m1_readdata;
   logic [ADDR_W-1:0]  dbus_address;
   logic [DATA_W-1:0]  dbus_writedata;
   logic [BE_W-1:0]    dbus_byteenable;
   logic [BURST_W-1:0] dbus_burstcount;
   logic               dbus_read, dbus_write, rsp_orphan;
   logic               ctl_wait, ctl_rdv;
   logic [DATA_W-1:0]  ctl_rdata;

   sdram_dbus_arbiter #(
      .RDQ_DEPTH (DEPTH)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .m0_address         (drv_addr[0]),
      .m0_writedata       (drv_wdata[0]),
      .m0_byteenable      (drv_be[0]),
      .m0_burstcount      (drv_bc[0]),
      .m0_read            (drv_rd[0]),
      .m0_write           (drv_wr[0]),
      .m0_waitrequest     (m0_waitrequest),
      .m0_readdata        (m0_readdata),
      .m0_readdatavalid   (m0_readdatavalid),
      .m1_address         (drv_addr[1]),
      .m1_writedata       (drv_wdata[1]),
      .m1_byteenable      (drv_be[1]),
      .m1_burstcount      (drv_bc[1]),
      .m1_read            (drv_rd[1]),
      .m1_write           (drv_wr[1]),
      .m1_waitrequest     (m1_waitrequest),
      .m1_readdata        (m1_readdata),
      .m1_readdatavalid   (m1_readdatavalid),
      .dbus_address       (dbus_address),
      .dbus_writedata     (dbus_writedata),
      .dbus_byteenable    (dbus_byteenable),
      .dbus_burstcount    (dbus_burstcount),
      .dbus_read          (dbus_read),
      .dbus_write         (dbus_write),
      .dbus_waitrequest   (ctl_wait),
      .dbus_readdata      (ctl_rdata),
      .dbus_readdatavalid (ctl_rdv),
      .rsp_orphan         (rsp_orphan)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int id;
      int cnt;
   } tag_t;

   // Reference model state
   tag_t tagq[$];
   int   lg, lock_id, beats_left, pending, s, bceff;
   bit   locked, orph, ew, er, acc;
   bit [1:0] el, wexp, rdv_exp, wt;
   // Master driver state
   bit   act [2], is_wr [2], started [2];
   int   left [2];

   task automatic model_reset();
      tagq.delete();
      lg = 1; locked = 0; lock_id = 0; beats_left = 0; orph = 0; pending = 0;
      for (int m = 0; m < 2; m++) begin
         act[m] = 0; started[m] = 0; left[m] = 0;
      end
   endtask

   initial begin
      int r;
      model_reset();
      rst = 1'b1;
      ctl_wait = 1'b0; ctl_rdv = 1'b0; ctl_rdata = '0;
      for (int m = 0; m < 2; m++) begin
         drv_addr[m] = '0; drv_wdata[m] = '0; drv_be[m] = '0; drv_bc[m] = '0;
         drv_rd[m] = 1'b0; drv_wr[m] = 1'b0;
      end

      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         @(negedge clk);
         rst = (cyc < 3) || ($urandom_range(0, 299) == 0);

         for (int m = 0; m < 2; m++) begin
            if (!act[m] && $urandom_range(0, 2) == 0) begin
               act[m]     = 1;
               is_wr[m]   = 1'($urandom_range(0, 1));
               started[m] = 0;
               r = $urandom_range(0, 19);
               drv_bc[m]    = BURST_W'((r >= 18 && !is_wr[m]) ? 127 : r % 9);
               left[m]      = (drv_bc[m] == 0) ? 1 : int'(drv_bc[m]);
               drv_addr[m]  = ADDR_W'($urandom());
               drv_be[m]    = BE_W'($urandom());
               drv_wdata[m] = DATA_W'($urandom());
            end
            drv_rd[m] = act[m] && !is_wr[m];
            drv_wr[m] = act[m] && is_wr[m] && !(started[m] && $urandom_range(0, 4) == 0);
         end

         ctl_wait  = ($urandom_range(0, 3) == 0);
         ctl_rdata = DATA_W'($urandom());
         if (pending > 0) ctl_rdv = 1'($urandom_range(0, 1));
         else             ctl_rdv = ($urandom_range(0, 149) == 0);

         #1;
         if (rst) begin
            check_eq("rst_dbus_write", dbus_write, 0);
            check_eq("rst_dbus_read", dbus_read, 0);
            check_eq("rst_m0_wait", m0_waitrequest, 1);
            check_eq("rst_m1_wait", m1_waitrequest, 1);
            check_eq("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
            model_reset();
            @(posedge clk);
            continue;
         end

         // Expected command path from grant rules
         wexp = 2'b11; ew = 0; er = 0; s = -1;
         if (locked) begin
            s = lock_id;
            ew = drv_wr[s];
            wexp[s] = ctl_wait;
         end else begin
            for (int m = 0; m < 2; m++)
               el[m] = drv_wr[m] || (drv_rd[m] && tagq.size() < DEPTH);
            if (el == 2'b11) s = (lg == 1) ? 0 : 1;
            else if (el[0]) s = 0;
            else if (el[1]) s = 1;
            if (s >= 0) begin
               ew = drv_wr[s];
               er = !drv_wr[s] && drv_rd[s];
               wexp[s] = ctl_wait;
            end
         end

         check_eq("dbus_write", dbus_write, ew);
         check_eq("dbus_read", dbus_read, er);
         if (ew || er) begin
            check_eq("dbus_address", dbus_address, drv_addr[s]);
            check_eq("dbus_burstcount", dbus_burstcount, drv_bc[s]);
            check_eq("dbus_byteenable", dbus_byteenable, drv_be[s]);
            if (ew) check_eq("dbus_writedata", dbus_writedata, drv_wdata[s]);
         end
         wt = {m1_waitrequest, m0_waitrequest};
         for (int m = 0; m < 2; m++)
            if (drv_rd[m] || drv_wr[m]) check_eq($sformatf("m%0d_wait", m), wt[m], wexp[m]);

         rdv_exp = 2'b00;
         if (ctl_rdv && tagq.size() > 0) rdv_exp[tagq[0].id] = 1'b1;
         check_eq("rdv", {m1_readdatavalid, m0_readdatavalid}, rdv_exp);
         if (ctl_rdv) begin
            check_eq("m0_readdata", m0_readdata, ctl_rdata);
            check_eq("m1_readdata", m1_readdata, ctl_rdata);
         end
         check_eq("rsp_orphan", rsp_orphan, orph);

         // Advance model for the coming edge
         if (ctl_rdv) begin
            if (tagq.size() > 0) begin
               tagq[0].cnt--;
               if (tagq[0].cnt == 0) void'(tagq.pop_front());
               pending--;
            end else begin
               orph = 1;
            end
         end
         acc = (ew || er) && !ctl_wait;
         if (acc) begin
            bceff = (drv_bc[s] == 0) ? 1 : int'(drv_bc[s]);
            if (er) begin
               tagq.push_back('{id: s, cnt: bceff});
               pending += bceff;
               lg = s;
               act[s] = 0;
            end else begin
               started[s] = 1;
               left[s]--;
               if (left[s] == 0) act[s] = 0;
               if (!locked) begin
                  if (bceff > 1) begin
                     locked = 1; lock_id = s; beats_left = bceff - 1;
                  end else begin
                     lg = s;
                  end
               end else begin
                  beats_left--;
                  if (beats_left == 0) begin
                     locked = 0; lg = s;
                  end
               end
            end
         end
         @(posedge clk);
         if (ew && acc) drv_wdata[s] = DATA_W'($urandom());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
